// File: rtl/gearbox_n2m_if.sv
// Valid/ready bundle for the N:M lane gearbox.
// Signal names carry the gearbox's own port direction suffixes.
interface gearbox_n2m_if #(
  parameter int IN_W    = 4,
  parameter int OUT_W   = 3,
  parameter int NGROUPS = 2
);
  function automatic int gcd(input int a, input int b);
    int x;
    int y;
    int t;
    x = a;
    y = b;
    while (y != 0) begin
      t = y;
      y = x % y;
      x = t;
    end
    return x;
  endfunction

  localparam int FRAME_N = IN_W / gcd(IN_W, OUT_W);
  localparam int PH_W    = (FRAME_N > 1) ? $clog2(FRAME_N) : 1;

  logic [NGROUPS*IN_W-1:0]  in_dat_i;
  logic                     in_valid_i;
  logic                     in_ready_o;
  logic                     align_i;
  logic                     slip_i;
  logic [NGROUPS*OUT_W-1:0] out_dat_o;
  logic                     out_valid_o;
  logic                     out_ready_i;
  logic [PH_W-1:0]          out_phase_o;
  logic                     out_frame_o;

  modport slave (
    input  in_dat_i, in_valid_i, align_i, slip_i, out_ready_i,
    output in_ready_o, out_dat_o, out_valid_o, out_phase_o, out_frame_o
  );

  modport master (
    output in_dat_i, in_valid_i, align_i, slip_i, out_ready_i,
    input  in_ready_o, out_dat_o, out_valid_o, out_phase_o, out_frame_o
  );
endinterface

// File: rtl/gearbox_n2m.sv
// IN_W:OUT_W multi-lane gearbox, LSB-first, with frame phase marking.
// Optional one-bit slip per lane is enabled by defining GEARBOX_SLIP_EN.
module gearbox_n2m #(
  parameter int IN_W    = 4,
  parameter int OUT_W   = 3,
  parameter int NGROUPS = 2
) (
  input logic clk,
  input logic rst_n,
  gearbox_n2m_if.slave bus
);
  function automatic int gcd(input int a, input int b);
    int x;
    int y;
    int t;
    x = a;
    y = b;
    while (y != 0) begin
      t = y;
      y = x % y;
      x = t;
    end
    return x;
  endfunction

  localparam int MAX_W   = (IN_W > OUT_W) ? IN_W : OUT_W;
  localparam int BUF_W   = 2 * MAX_W;
  localparam int CNT_W   = $clog2(BUF_W + 1);
  localparam int FRAME_N = IN_W / gcd(IN_W, OUT_W);
  localparam int PH_W    = (FRAME_N > 1) ? $clog2(FRAME_N) : 1;

  localparam logic [CNT_W-1:0] IN_C   = CNT_W'(IN_W);
  localparam logic [CNT_W-1:0] OUT_C  = CNT_W'(OUT_W);
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(BUF_W - IN_W);
  localparam logic [PH_W-1:0]  PH_END = PH_W'(FRAME_N - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [NGROUPS-1:0][BUF_W-1:0] buf_q, buf_d;

  logic in_ready;
  logic out_valid;
  logic push;
  logic pop;
  logic slip;
  logic [CNT_W-1:0] wr_pos;

`ifdef GEARBOX_SLIP_EN
  assign slip = bus.slip_i && (cnt_q != '0) && !bus.align_i;
`else
  logic unused_slip;
  assign unused_slip = bus.slip_i;
  assign slip        = 1'b0;
`endif

  // Flags come from registered cnt only; slip just masks them off
  assign in_ready  = (cnt_q <= FULL_C) && !slip;
  assign out_valid = (cnt_q >= OUT_C) && !slip;
  assign push      = bus.in_valid_i && in_ready;
  assign pop       = out_valid && bus.out_ready_i;
  assign wr_pos    = pop ? (cnt_q - OUT_C) : cnt_q;

  always_comb begin
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    phase_d = phase_q;
    if (bus.align_i) begin
      cnt_d   = '0;
      buf_d   = '0;
      phase_d = '0;
    end else if (slip) begin
      for (int g = 0; g < NGROUPS; g++) begin
        buf_d[g] = buf_q[g] >> 1;
      end
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      if (pop) begin
        for (int g = 0; g < NGROUPS; g++) begin
          buf_d[g] = buf_q[g] >> OUT_W;
        end
        cnt_d   = cnt_q - OUT_C;
        phase_d = (phase_q == PH_END) ? '0 : phase_q + PH_W'(1);
      end
      // Bits above cnt are always zero, so OR-in is a clean insert
      if (push) begin
        for (int g = 0; g < NGROUPS; g++) begin
          buf_d[g] = buf_d[g]
            | (BUF_W'(bus.in_dat_i[g*IN_W +: IN_W]) << wr_pos);
        end
        cnt_d = cnt_d + IN_C;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      buf_q   <= '0;
      phase_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    for (int g = 0; g < NGROUPS; g++) begin
      bus.out_dat_o[g*OUT_W +: OUT_W] = buf_q[g][OUT_W-1:0];
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid;
  assign bus.out_phase_o = phase_q;
  assign bus.out_frame_o = out_valid && (phase_q == '0);
endmodule
